// File: rtl/rr_arbiter_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rr_arbiter_n
//  Description : N-way clocked arbiter, round-robin or fixed priority, with
//                a valid/ready winner channel, ownership lock and a
//                post-grant idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int MODE  = 0,
  parameter int BL    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             lock,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     grant,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [N-1:0]     c_one      = N'(1);
  localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(N - 1);
  localparam logic [3:0]       c_bl       = 4'(BL);

  state_t           state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic [N-1:0]     grant_q,     grant_d;
  logic [IDX_W-1:0] last_q,      last_d;
  logic             lock_hold_q, lock_hold_d;
  logic [3:0]       cnt_q,       cnt_d;

  logic             w_win_found;
  logic [IDX_W-1:0] w_win_idx;

  // Index reached by stepping k places past base, wrapping at N.
  function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Winner selection: held lock owner first, then rotating or lowest-index search.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    if (lock_hold_q && req[last_q]) begin
      w_win_found = 1'b1;
      w_win_idx   = last_q;
    end else if (MODE == 0) begin
      for (int k = 1; k <= N; k++) begin
        if (!w_win_found && req[rr_pos(last_q, k)]) begin
          w_win_found = 1'b1;
          w_win_idx   = rr_pos(last_q, k);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!w_win_found && req[k]) begin
          w_win_found = 1'b1;
          w_win_idx   = IDX_W'(k);
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE/OFFER/GAP sequence.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    grant_d     = grant_q;
    last_d      = last_q;
    lock_hold_d = lock_hold_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A lock is honoured at most once and is dropped if its owner stops requesting.
        lock_hold_d = 1'b0;
        if (w_win_found) begin
          state_d     = ST_OFFER;
          out_valid_d = 1'b1;
          out_idx_d   = w_win_idx;
          grant_d     = c_one << w_win_idx;
        end
      end
      ST_OFFER: begin
        // The offer is held until accepted; requester changes do not retract it.
        if (out_ready) begin
          out_valid_d = 1'b0;
          grant_d     = '0;
          last_d      = out_idx_q;
          lock_hold_d = lock & req[out_idx_q];
          if (BL == 0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = c_bl;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous reset; last starts at N-1 so requester 0 leads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      grant_q     <= '0;
      last_q      <= c_last_rst;
      lock_hold_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      lock_hold_q <= lock_hold_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rr_arbiter_n
//  Description : Directed self-checking bench for rr_arbiter_n with a
//                queue of expected winner indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_n;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic [N-1:0]     req      = '0;
  logic [N-1:0]     req_fp   = '0;
  logic             lock     = 1'b0;
  logic             lock_fp  = 1'b0;
  logic             out_ready = 1'b1;
  logic             ready_fp = 1'b1;

  logic             rr_valid, fp_valid;
  logic [IDX_W-1:0] rr_idx,   fp_idx;
  logic [N-1:0]     rr_grant, fp_grant;
  logic             rr_busy,  fp_busy;

  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   seen_cyc = 0;
  int   prev_cyc = 0;
  logic sel_fp   = 1'b0;
  int   exp_q[$];

  rr_arbiter_n #(.N(N), .IDX_W(IDX_W), .MODE(0), .BL(1)) u_rr (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .out_valid(rr_valid), .out_ready(out_ready), .out_idx(rr_idx),
    .grant(rr_grant), .busy(rr_busy)
  );

  rr_arbiter_n #(.N(N), .IDX_W(IDX_W), .MODE(1), .BL(1)) u_fp (
    .clk(clk), .reset(reset), .req(req_fp), .lock(lock_fp),
    .out_valid(fp_valid), .out_ready(ready_fp), .out_idx(fp_idx),
    .grant(fp_grant), .busy(fp_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for an offer from the selected DUT, then pop and compare.
  task automatic wait_grant(input string tag);
    int               n;
    int               e;
    logic             v;
    logic [IDX_W-1:0] ix;
    logic [N-1:0]     g;
    logic             b;
    logic [N-1:0]     one;
    n   = 0;
    v   = 1'b0;
    one = 4'b0001;
    while (!v && n < 30) begin
      @(negedge clk);
      n++;
      v = sel_fp ? fp_valid : rr_valid;
    end
    ix = sel_fp ? fp_idx   : rr_idx;
    g  = sel_fp ? fp_grant : rr_grant;
    b  = sel_fp ? fp_busy  : rr_busy;
    seen_cyc = cyc;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    chk({tag, ".valid"}, 32'(v), 32'd1);
    chk({tag, ".idx"},   32'(ix), 32'(e));
    chk({tag, ".grant"}, 32'(g), 32'(one << e));
    chk({tag, ".busy"},  32'(b), 32'd1);
  endtask

  initial begin
    int seq1[5];
    int seq2[3];
    seq1 = '{0, 1, 2, 3, 0};
    seq2 = '{3, 0, 3};

    // Reset state
    #2;
    chk("rst.valid", 32'(rr_valid), 32'd0);
    chk("rst.idx",   32'(rr_idx),   32'd0);
    chk("rst.grant", 32'(rr_grant), 32'd0);
    chk("rst.busy",  32'(rr_busy),  32'd0);
    chk("rst.fp_valid", 32'(fp_valid), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;

    // Round-robin order from reset and 3-cycle grant period
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(seq1[i]);
      wait_grant("rr_seq");
      if (i > 0) chk("rr_period", 32'(seen_cyc - prev_cyc), 32'd3);
      prev_cyc = seen_cyc;
    end

    // Wrap-around with req=1001 (last winner was 0)
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq2[i]);
      wait_grant("wrap");
    end
    req = 4'b0110;
    exp_q.push_back(1);
    wait_grant("wrap_inj");
    req = 4'b0000;

    // Fixed priority on the second instance
    sel_fp = 1'b1;
    req_fp = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1);
      wait_grant("fixed1");
    end
    req_fp = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(2);
      wait_grant("fixed2");
    end
    req_fp = 4'b0000;
    sel_fp = 1'b0;

    // Backpressure: offer held for 5 cycles, req dropped mid-offer
    @(negedge clk);
    out_ready = 1'b0;
    req       = 4'b0100;
    exp_q.push_back(2);
    wait_grant("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) req = 4'b0000;
      chk("bp_hold.valid", 32'(rr_valid), 32'd1);
      chk("bp_hold.idx",   32'(rr_idx),   32'd2);
      chk("bp_hold.grant", 32'(rr_grant), 32'h4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs.valid", 32'(rr_valid), 32'd0);
    chk("bp_hs.grant", 32'(rr_grant), 32'd0);
    chk("bp_hs.busy",  32'(rr_busy),  32'd1);

    // Lock keeps ownership for exactly one extra arbitration
    req  = 4'b0011;
    lock = 1'b0;
    exp_q.push_back(0);
    wait_grant("lock_a");
    lock = 1'b1;
    exp_q.push_back(0);
    wait_grant("lock_b");
    lock = 1'b0;
    exp_q.push_back(1);
    wait_grant("lock_c");

    // Asynchronous reset in the middle of an offer
    @(negedge clk);
    out_ready = 1'b0;
    req       = 4'b1111;
    exp_q.push_back(2);
    wait_grant("pre_rst");
    #1 reset = 1'b1;
    #1;
    chk("arst.valid", 32'(rr_valid), 32'd0);
    chk("arst.grant", 32'(rr_grant), 32'd0);
    chk("arst.busy",  32'(rr_busy),  32'd0);
    chk("arst.idx",   32'(rr_idx),   32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(0);
    wait_grant("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
